// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Holds one EX entry and presents forwarded ALU operands, control and load-use detection.
module ex_operand_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_rs_data,
    input  logic [31:0] i_id_rt_data,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic [4:0]  i_id_dst,
    input  logic [15:0] i_id_imm,
    input  logic [4:0]  i_id_shamt,
    input  logic [3:0]  i_id_aluc,
    input  logic        i_id_alusrc,
    input  logic        i_id_sext,
    input  logic        i_id_shift,
    input  logic        i_id_vshift,
    input  logic        i_id_regwrite,
    input  logic        i_id_memread,
    input  logic        i_id_memwrite,
    input  logic        i_mem_regwrite,
    input  logic [4:0]  i_mem_dst,
    input  logic [31:0] i_mem_result,
    input  logic        i_wb_regwrite,
    input  logic [4:0]  i_wb_dst,
    input  logic [31:0] i_wb_result,
    output logic        o_valid,
    output logic [31:0] o_r,
    output logic [31:0] o_s,
    output logic [3:0]  o_aluc,
    output logic [31:0] o_store_data,
    output logic [4:0]  o_dst,
    output logic        o_regwrite,
    output logic        o_memread,
    output logic        o_memwrite,
    output logic [1:0]  o_fwd_r,
    output logic [1:0]  o_fwd_s,
    output logic        o_load_use
);

    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    logic        r_vld_p1;
    logic [31:0] r_rs_data_p1;
    logic [31:0] r_rt_data_p1;
    logic [4:0]  r_rs_p1;
    logic [4:0]  r_rt_p1;
    logic [4:0]  r_dst_p1;
    logic [15:0] r_imm_p1;
    logic [4:0]  r_shamt_p1;
    logic [3:0]  r_aluc_p1;
    logic        r_alusrc_p1;
    logic        r_sext_p1;
    logic        r_shift_p1;
    logic        r_vshift_p1;
    logic        r_regwrite_p1;
    logic        r_memread_p1;
    logic        r_memwrite_p1;

    logic [1:0]         w_sel_rs;
    logic [1:0]         w_sel_rt;
    logic [31:0]        w_fwd_rs;
    logic [31:0]        w_fwd_rt;
    logic signed [31:0] w_imm_ext;

    // MEM is the younger producer, so it wins over WB; $0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] idx, input logic mem_we,
                                           input logic [4:0] mem_dst, input logic wb_we,
                                           input logic [4:0] wb_dst);
        logic [1:0] sel;
        sel = SEL_REG;
        if (idx != 5'd0 && mem_we && mem_dst == idx)
            sel = SEL_MEM;
        else if (idx != 5'd0 && wb_we && wb_dst == idx)
            sel = SEL_WB;
        return sel;
    endfunction

    function automatic logic signed [31:0] ext_imm(input logic [15:0] imm, input logic sext);
        logic signed [31:0] v;
        if (sext)
            v = $signed({{16{imm[15]}}, imm});
        else
            v = $signed({16'b0, imm});
        return v;
    endfunction

    always_comb begin
        w_sel_rs = fwd_sel(r_rs_p1, i_mem_regwrite, i_mem_dst, i_wb_regwrite, i_wb_dst);
        w_sel_rt = fwd_sel(r_rt_p1, i_mem_regwrite, i_mem_dst, i_wb_regwrite, i_wb_dst);
        case (w_sel_rs)
            SEL_MEM: w_fwd_rs = i_mem_result;
            SEL_WB:  w_fwd_rs = i_wb_result;
            default: w_fwd_rs = r_rs_data_p1;
        endcase
        case (w_sel_rt)
            SEL_MEM: w_fwd_rt = i_mem_result;
            SEL_WB:  w_fwd_rt = i_wb_result;
            default: w_fwd_rt = r_rt_data_p1;
        endcase
        w_imm_ext = ext_imm(r_imm_p1, r_sext_p1);
    end

    // ---- ID -> EX register boundary ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1      <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_memread_p1  <= 1'b0;
            r_memwrite_p1 <= 1'b0;
            r_rs_data_p1  <= '0;
            r_rt_data_p1  <= '0;
            r_rs_p1       <= '0;
            r_rt_p1       <= '0;
            r_dst_p1      <= '0;
            r_imm_p1      <= '0;
            r_shamt_p1    <= '0;
            r_aluc_p1     <= '0;
            r_alusrc_p1   <= 1'b0;
            r_sext_p1     <= 1'b0;
            r_shift_p1    <= 1'b0;
            r_vshift_p1   <= 1'b0;
        end else if (i_flush) begin
            r_vld_p1      <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_memread_p1  <= 1'b0;
            r_memwrite_p1 <= 1'b0;
        end else if (i_stall) begin
            // Capture forwarded operands so they survive the producer retiring mid-stall.
            r_rs_data_p1  <= w_fwd_rs;
            r_rt_data_p1  <= w_fwd_rt;
        end else begin
            r_vld_p1      <= i_id_valid;
            r_regwrite_p1 <= i_id_regwrite;
            r_memread_p1  <= i_id_memread;
            r_memwrite_p1 <= i_id_memwrite;
            r_rs_data_p1  <= i_id_rs_data;
            r_rt_data_p1  <= i_id_rt_data;
            r_rs_p1       <= i_id_rs;
            r_rt_p1       <= i_id_rt;
            r_dst_p1      <= i_id_dst;
            r_imm_p1      <= i_id_imm;
            r_shamt_p1    <= i_id_shamt;
            r_aluc_p1     <= i_id_aluc;
            r_alusrc_p1   <= i_id_alusrc;
            r_sext_p1     <= i_id_sext;
            r_shift_p1    <= i_id_shift;
            r_vshift_p1   <= i_id_vshift;
        end
    end

    // ---- EX operand outputs ----
    always_comb begin
        o_valid      = r_vld_p1;
        o_aluc       = r_aluc_p1;
        o_dst        = r_dst_p1;
        o_regwrite   = r_vld_p1 & r_regwrite_p1;
        o_memread    = r_vld_p1 & r_memread_p1;
        o_memwrite   = r_vld_p1 & r_memwrite_p1;
        o_store_data = w_fwd_rt;
        o_fwd_s      = w_sel_rt;
        if (r_shift_p1) begin
            o_r     = {27'b0, r_shamt_p1};
            o_fwd_r = SEL_REG;
        end else if (r_vshift_p1) begin
            o_r     = {27'b0, w_fwd_rs[4:0]};
            o_fwd_r = w_sel_rs;
        end else begin
            o_r     = w_fwd_rs;
            o_fwd_r = w_sel_rs;
        end
        o_s        = r_alusrc_p1 ? w_imm_ext : w_fwd_rt;
        o_load_use = o_valid & o_memread & (o_dst != 5'd0) &
                     ((o_dst == i_id_rs) | (o_dst == i_id_rt));
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed test-plan steps followed by random traffic,
// all checked against an entry-level reference model of the ID/EX register.
module tb_ex_operand_stage;

    logic        i_clk = 1'b0;
    logic        i_rst, i_stall, i_flush, i_id_valid;
    logic [31:0] i_id_rs_data, i_id_rt_data;
    logic [4:0]  i_id_rs, i_id_rt, i_id_dst, i_id_shamt;
    logic [15:0] i_id_imm;
    logic [3:0]  i_id_aluc;
    logic        i_id_alusrc, i_id_sext, i_id_shift, i_id_vshift;
    logic        i_id_regwrite, i_id_memread, i_id_memwrite;
    logic        i_mem_regwrite, i_wb_regwrite;
    logic [4:0]  i_mem_dst, i_wb_dst;
    logic [31:0] i_mem_result, i_wb_result;
    logic        o_valid, o_regwrite, o_memread, o_memwrite, o_load_use;
    logic [31:0] o_r, o_s, o_store_data;
    logic [3:0]  o_aluc;
    logic [4:0]  o_dst;
    logic [1:0]  o_fwd_r, o_fwd_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] rs_data, rt_data;
        logic [4:0]  rs, rt, dst, shamt;
        logic [15:0] imm;
        logic [3:0]  aluc;
        logic        alusrc, sext, shift, vshift, rw, mr, mw;
        logic        known;
    } ent_t;

    ent_t m, m_nxt;
    logic m_init = 1'b0;

    ex_operand_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_id_valid(i_id_valid), .i_id_rs_data(i_id_rs_data), .i_id_rt_data(i_id_rt_data),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_dst(i_id_dst), .i_id_imm(i_id_imm),
        .i_id_shamt(i_id_shamt), .i_id_aluc(i_id_aluc), .i_id_alusrc(i_id_alusrc),
        .i_id_sext(i_id_sext), .i_id_shift(i_id_shift), .i_id_vshift(i_id_vshift),
        .i_id_regwrite(i_id_regwrite), .i_id_memread(i_id_memread), .i_id_memwrite(i_id_memwrite),
        .i_mem_regwrite(i_mem_regwrite), .i_mem_dst(i_mem_dst), .i_mem_result(i_mem_result),
        .i_wb_regwrite(i_wb_regwrite), .i_wb_dst(i_wb_dst), .i_wb_result(i_wb_result),
        .o_valid(o_valid), .o_r(o_r), .o_s(o_s), .o_aluc(o_aluc), .o_store_data(o_store_data),
        .o_dst(o_dst), .o_regwrite(o_regwrite), .o_memread(o_memread), .o_memwrite(o_memwrite),
        .o_fwd_r(o_fwd_r), .o_fwd_s(o_fwd_s), .o_load_use(o_load_use)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Which stage currently holds the newest value of register idx (0 reg, 1 MEM, 2 WB).
    function automatic logic [1:0] src_of(input logic [4:0] idx);
        if (idx == 5'd0) return 2'd0;
        if (i_mem_regwrite && i_mem_dst == idx) return 2'd1;
        if (i_wb_regwrite && i_wb_dst == idx) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] regval);
        logic [1:0] s;
        s = src_of(idx);
        if (s == 2'd1) return i_mem_result;
        if (s == 2'd2) return i_wb_result;
        return regval;
    endfunction

    task automatic check_all();
        logic [31:0] frs, frt, ext, er, es;
        frs = value_of(m.rs, m.rs_data);
        frt = value_of(m.rt, m.rt_data);
        ext = m.sext ? 32'(signed'(m.imm)) : 32'(m.imm);
        er  = m.shift ? 32'(m.shamt) : (m.vshift ? 32'(frs % 32) : frs);
        es  = m.alusrc ? ext : frt;
        chk("valid", 32'(o_valid), 32'(m.valid));
        chk("regwrite", 32'(o_regwrite), 32'(m.valid & m.rw));
        chk("memread", 32'(o_memread), 32'(m.valid & m.mr));
        chk("memwrite", 32'(o_memwrite), 32'(m.valid & m.mw));
        chk("load_use", 32'(o_load_use),
            32'(m.valid && m.mr && m.dst != 0 && (m.dst == i_id_rs || m.dst == i_id_rt)));
        if (m.known) begin
            chk("r", o_r, er);
            chk("s", o_s, es);
            chk("store_data", o_store_data, frt);
            chk("aluc", 32'(o_aluc), 32'(m.aluc));
            chk("dst", 32'(o_dst), 32'(m.dst));
            chk("fwd_r", 32'(o_fwd_r), m.shift ? 32'd0 : 32'(src_of(m.rs)));
            chk("fwd_s", 32'(o_fwd_s), 32'(src_of(m.rt)));
        end
    endtask

    task automatic model_step();
        m_nxt = m;
        if (i_rst) begin
            m_nxt = '{valid: 1'b0, rs_data: '0, rt_data: '0, rs: '0, rt: '0, dst: '0, shamt: '0,
                      imm: '0, aluc: '0, alusrc: 1'b0, sext: 1'b0, shift: 1'b0, vshift: 1'b0,
                      rw: 1'b0, mr: 1'b0, mw: 1'b0, known: 1'b1};
        end else if (i_flush) begin
            m_nxt.valid = 1'b0;
            m_nxt.rw = 1'b0; m_nxt.mr = 1'b0; m_nxt.mw = 1'b0;
            m_nxt.known = 1'b0;
        end else if (i_stall) begin
            m_nxt.rs_data = value_of(m.rs, m.rs_data);
            m_nxt.rt_data = value_of(m.rt, m.rt_data);
        end else begin
            m_nxt = '{valid: i_id_valid, rs_data: i_id_rs_data, rt_data: i_id_rt_data,
                      rs: i_id_rs, rt: i_id_rt, dst: i_id_dst, shamt: i_id_shamt, imm: i_id_imm,
                      aluc: i_id_aluc, alusrc: i_id_alusrc, sext: i_id_sext, shift: i_id_shift,
                      vshift: i_id_vshift, rw: i_id_regwrite, mr: i_id_memread,
                      mw: i_id_memwrite, known: 1'b1};
        end
    endtask

    // Check the current entry, then advance one clock edge together with the model.
    task automatic tick();
        #1;
        if (m_init) check_all();
        model_step();
        @(posedge i_clk);
        m = m_nxt;
        if (i_rst) m_init = 1'b1;
        #1;
    endtask

    task automatic id_instr(input logic [4:0] rs, rt, dst, input logic [31:0] rsd, rtd,
                            input logic rw, mr);
        i_id_valid = 1'b1; i_id_rs = rs; i_id_rt = rt; i_id_dst = dst;
        i_id_rs_data = rsd; i_id_rt_data = rtd; i_id_imm = 16'h0; i_id_shamt = 5'd0;
        i_id_aluc = 4'h2; i_id_alusrc = 1'b0; i_id_sext = 1'b0; i_id_shift = 1'b0;
        i_id_vshift = 1'b0; i_id_regwrite = rw; i_id_memread = mr; i_id_memwrite = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        i_mem_regwrite = 1'b0; i_mem_dst = '0; i_mem_result = '0;
        i_wb_regwrite = 1'b0; i_wb_dst = '0; i_wb_result = '0;
        id_instr(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(); tick();
        i_rst = 1'b0;

        id_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b1, 1'b0);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_regwrite", 32'(o_regwrite), 32'd0);
        chk("rst_memread", 32'(o_memread), 32'd0);
        chk("rst_aluc", 32'(o_aluc), 32'd0);
        chk("rst_r", o_r, 32'd0);
        chk("rst_s", o_s, 32'd0);
        tick();

        id_instr(5'd4, 5'd5, 5'd6, 32'h99, 32'h55, 1'b1, 1'b0);
        #1;
        chk("add_r", o_r, 32'd5);
        chk("add_s", o_s, 32'd7);
        chk("add_fwd_r", 32'(o_fwd_r), 32'd0);
        chk("add_fwd_s", 32'(o_fwd_s), 32'd0);
        chk("add_regwrite", 32'(o_regwrite), 32'd1);
        tick();

        i_mem_regwrite = 1'b1; i_mem_dst = 5'd4; i_mem_result = 32'h11;
        i_wb_regwrite = 1'b1; i_wb_dst = 5'd4; i_wb_result = 32'h22;
        #1;
        chk("dbl_r", o_r, 32'h11);
        chk("dbl_fwd_r", 32'(o_fwd_r), 32'd1);
        i_mem_dst = 5'd0; i_wb_dst = 5'd0;
        id_instr(5'd1, 5'd2, 5'd9, 32'd0, 32'd0, 1'b1, 1'b0);
        i_id_alusrc = 1'b1; i_id_sext = 1'b1; i_id_imm = 16'hFFF0;
        #1;
        chk("dst0_r", o_r, 32'h99);
        chk("dst0_fwd_r", 32'(o_fwd_r), 32'd0);
        tick();

        i_mem_regwrite = 1'b0; i_wb_regwrite = 1'b0;
        i_id_sext = 1'b0;
        #1;
        chk("imm_sext", o_s, 32'hFFFF_FFF0);
        tick();
        id_instr(5'd6, 5'd2, 5'd9, 32'h1234, 32'd0, 1'b1, 1'b0);
        i_id_shift = 1'b1; i_id_shamt = 5'd3;
        #1;
        chk("imm_zext", o_s, 32'h0000_FFF0);
        tick();
        i_mem_regwrite = 1'b1; i_mem_dst = 5'd6; i_mem_result = 32'hDEAD;
        id_instr(5'd1, 5'd7, 5'd10, 32'd0, 32'h1111, 1'b1, 1'b0);
        #1;
        chk("sll_r", o_r, 32'd3);
        chk("sll_fwd_r", 32'(o_fwd_r), 32'd0);
        tick();

        i_mem_regwrite = 1'b0;
        i_wb_regwrite = 1'b1; i_wb_dst = 5'd7; i_wb_result = 32'hABCD;
        i_stall = 1'b1;
        #1;
        chk("stall_s0", o_s, 32'hABCD);
        tick();
        i_wb_regwrite = 1'b0; i_wb_result = 32'h5555;
        #1;
        chk("stall_s1", o_s, 32'hABCD);
        tick();
        i_stall = 1'b0;
        #1;
        chk("stall_s2", o_s, 32'hABCD);
        chk("stall_valid", 32'(o_valid), 32'd1);
        tick();
        i_stall = 1'b1; i_flush = 1'b1;
        tick();
        i_stall = 1'b0; i_flush = 1'b0;
        #1;
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_regwrite", 32'(o_regwrite), 32'd0);

        id_instr(5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        i_id_rs = 5'd3; i_id_rt = 5'd8;
        #1;
        chk("lu_hit", 32'(o_load_use), 32'd1);
        i_id_rs = 5'd9; i_id_rt = 5'd9;
        #1;
        chk("lu_miss", 32'(o_load_use), 32'd0);
        id_instr(5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        i_id_rs = 5'd0; i_id_rt = 5'd0;
        #1;
        chk("lu_dst0", 32'(o_load_use), 32'd0);

        id_instr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b1, 1'b0);
        tick();
        i_stall = 1'b1; i_rst = 1'b1;
        tick();
        i_stall = 1'b0; i_rst = 1'b0;
        #1;
        chk("rst_in_stall_valid", 32'(o_valid), 32'd0);
        chk("rst_in_stall_r", o_r, 32'd0);

        for (int n = 0; n < 400; n++) begin
            i_rst          = ($urandom_range(0, 63) == 0);
            i_flush        = ($urandom_range(0, 15) == 0);
            i_stall        = ($urandom_range(0, 4) == 0);
            i_id_valid     = 1'($urandom);
            i_id_rs_data   = $urandom;
            i_id_rt_data   = $urandom;
            i_id_rs        = 5'($urandom_range(0, 7));
            i_id_rt        = 5'($urandom_range(0, 7));
            i_id_dst       = 5'($urandom_range(0, 7));
            i_id_imm       = 16'($urandom);
            i_id_shamt     = 5'($urandom);
            i_id_aluc      = 4'($urandom);
            i_id_alusrc    = 1'($urandom);
            i_id_sext      = 1'($urandom);
            i_id_shift     = ($urandom_range(0, 3) == 0);
            i_id_vshift    = ($urandom_range(0, 3) == 0);
            i_id_regwrite  = 1'($urandom);
            i_id_memread   = 1'($urandom);
            i_id_memwrite  = 1'($urandom);
            i_mem_regwrite = 1'($urandom);
            i_mem_dst      = 5'($urandom_range(0, 7));
            i_mem_result   = $urandom;
            i_wb_regwrite  = 1'($urandom);
            i_wb_dst       = 5'($urandom_range(0, 7));
            i_wb_result    = $urandom;
            tick();
        end
        i_rst = 1'b0; i_flush = 1'b0; i_stall = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
